// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART encodings, state enum and line constants
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic LINE_IDLE = 1'b1;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// rtl/uart_bit_timer.sv - bit-period counter with synchronous clear and bit_end strobe
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic bit_end
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Period counter: held at zero while cleared, otherwise counts 0..CLKS_PER_BIT-1 and wraps
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clear || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx_engine.sv
// rtl/uart_tx_engine.sv - parametrised UART transmitter (start, data, parity, stop)
module uart_tx_engine
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  tx_ready,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_two,
  output logic                  txd,
  output logic                  busy,
  output logic                  done
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 1);

  tx_state_t             state;
  tx_state_t             next_state;
  logic                  bit_end;
  logic                  timer_clear;
  logic [BIT_W-1:0]      bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  par_bit;
  logic                  par_en;
  logic                  stop_two_q;
  logic                  txd_next;
  logic                  accept;
  logic                  last_data;
  logic                  last_stop;

  assign accept      = tx_valid && tx_ready;
  assign timer_clear = (state == IDLE);
  assign last_data   = (bit_cnt == BIT_W'(DATA_WIDTH - 1));
  assign last_stop   = (bit_cnt == (stop_two_q ? BIT_W'(1) : BIT_W'(0)));

  // The timer is held cleared in IDLE so the start bit always begins at count zero
  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (timer_clear),
    .bit_end(bit_end)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: every non-idle state advances only on a bit boundary
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = START;
      START:   if (bit_end) next_state = DATA;
      DATA:    if (bit_end && last_data) next_state = par_en ? PARITY : STOP;
      PARITY:  if (bit_end) next_state = STOP;
      STOP:    if (bit_end && last_stop) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Outputs: handshake and status from state, line level chosen for the coming cycle
  always_comb begin
    tx_ready = (state == IDLE);
    busy     = (state != IDLE);
    done     = (state == STOP) && bit_end && last_stop;
    txd_next = LINE_IDLE;
    case (next_state)
      START:   txd_next = 1'b0;
      DATA:    txd_next = (state == DATA && bit_end) ? shift_reg[1] : shift_reg[0];
      PARITY:  txd_next = par_bit;
      default: txd_next = LINE_IDLE;
    endcase
  end

  // Registered serial line; reset forces it high immediately
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      txd <= LINE_IDLE;
    end else begin
      txd <= txd_next;
    end
  end

  // Bit counter: counts data bits in DATA and stop bits in STOP, cleared on every state change
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_cnt <= '0;
    end else if (state != next_state) begin
      bit_cnt <= '0;
    end else if (bit_end) begin
      bit_cnt <= bit_cnt + BIT_W'(1);
    end
  end

  // Frame capture on accept; parity comes from the whole latched word, not the shifting copy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_reg  <= '0;
      par_bit    <= 1'b0;
      par_en     <= 1'b0;
      stop_two_q <= 1'b0;
    end else if (accept) begin
      shift_reg  <= tx_data;
      par_bit    <= (^tx_data) ^ (parity_mode == PAR_ODD);
      par_en     <= (parity_mode == PAR_EVEN) || (parity_mode == PAR_ODD);
      stop_two_q <= stop_two;
    end else if (state == DATA && bit_end) begin
      shift_reg  <= shift_reg >> 1;
    end
  end

endmodule

// File: doc/uart_tx_engine.md
# uart_tx_engine

Parametrised UART transmitter, successor to the fixed 8-bit transmit FSM. It accepts parallel words over a valid/ready handshake and serialises them LSB-first as start, data, optional parity and one or two stop bits. Bit timing comes from an internal bit-period counter. It sits between the host-side register/FIFO logic and the `txd` pad.

## Interface
- `DATA_WIDTH`, 8: data bits per frame, legal 5..9.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit, legal ≥2.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `tx_data`  in  DATA_WIDTH  word to send, captured on handshake.
- `tx_valid`  in  1  `tx_data` is valid.
- `tx_ready`  out  1  engine can accept a word (high only in IDLE).
- `parity_mode`  in  2  00 none, 01 even, 10 odd, 11 none; captured on handshake.
- `stop_two`  in  1  0 = one stop bit, 1 = two; captured on handshake.
- `txd`  out  1  serial line, idle high, registered.
- `busy`  out  1  frame in progress (START..STOP).
- `done`  out  1  one-cycle pulse in the final clock of the last stop bit.

## Operation
- Reset values: state IDLE, `txd`=1, `busy`=0, `done`=0, `tx_ready`=1, all counters 0.
- Handshake: a word is accepted on a rising edge with `tx_valid && tx_ready`. `tx_data`, `parity_mode` and `stop_two` are latched in the same edge and are don't-care afterwards.
- `tx_valid` outside IDLE is ignored; no queueing.
- States and transitions:
  - IDLE → START on accept.
  - START → DATA after 1 bit period.
  - DATA → PARITY after DATA_WIDTH bit periods if parity is enabled, otherwise DATA → STOP.
  - PARITY → STOP after 1 bit period.
  - STOP → IDLE after 1 bit period, or 2 if `stop_two`.
- Line levels:
  - START drives `txd`=0.
  - DATA drives `shift_reg[0]` and shifts right once per bit period.
  - PARITY: even mode sends the XOR of the latched data; odd mode sends its inverse.
  - STOP drives `txd`=1.
- Parity is computed from the latched word at accept, not from the shifting register.
- Bit counter width is `$clog2(DATA_WIDTH+1)`; period counter width is `$clog2(CLKS_PER_BIT)`.
- The period counter runs 0..CLKS_PER_BIT-1 and wraps. A bit boundary is the cycle where the counter equals CLKS_PER_BIT-1.
- Reset mid-frame: the frame is abandoned, `txd` goes high asynchronously, and the engine returns to IDLE. No `done` pulse.

## Timing
- Accept edge at cycle 0; `txd` falls at cycle 1 (registered output). `busy` rises and `tx_ready` falls at the same edge.
- Frame length F = (1 + DATA_WIDTH + P + S) × CLKS_PER_BIT cycles, where P is 0/1 and S is 1/2.
- `done` is high during the last cycle of the frame (cycle F). At the following edge the state is IDLE, `busy`=0 and `tx_ready`=1.
- Back-to-back: the earliest next accept is the edge ending cycle F+1. The new start bit begins at F+2, giving exactly one idle-high cycle between frames.
- `tx_ready` is a function of state only; it never depends combinationally on `tx_valid`.

## Structure
- Shared package `uart_pkg` holds:
  - parity mode encodings (`PAR_NONE`, `PAR_EVEN`, `PAR_ODD`);
  - the state enum (IDLE, START, DATA, PARITY, STOP);
  - the idle line-level constant.
- The receiver later imports the same package.
- One sub-module, `uart_bit_timer`. It holds the CLKS_PER_BIT period counter with synchronous clear and emits a `bit_end` strobe. The receiver reuses it with a half-period option added later.

## Test plan
- Reset: assert `rst` low mid-idle → `txd`=1, `tx_ready`=1, `busy`=0, `done`=0. Assert `rst` low mid-frame → `txd` high immediately and no `done`.
- 8N1, CLKS_PER_BIT=4, `tx_data`=0xA5 → `txd` sequence 0,1,0,1,0,0,1,0,1,1, each level held 4 cycles; 40-cycle frame; `done` pulse at cycle 40.
- Even parity, `tx_data`=0x07 → parity bit 1. Odd parity, `tx_data`=0x00 → parity bit 1. Frame is 11 bit periods in both cases.
- `stop_two`=1, no parity, 0xFF → `txd` high for 10 trailing bit periods after the start bit (8 data + 2 stop); `done` only at the end of the second stop bit.
- Back-to-back: `tx_valid` held high with 0x3C then 0xC3 → second start bit begins exactly 1 idle cycle after the first frame ends. `tx_data` changed during busy does not alter the first frame.
- DATA_WIDTH=5 and DATA_WIDTH=9 builds: 0x15 (5-bit) and 0x1AA (9-bit) → correct LSB-first bit count and frame length.
